// File: rtl/oled_seq_pkg.sv
// oled_seq_pkg: shared FSM states, register offsets, bus constants and
// STATUS layout for the OLED command sequencer.
package oled_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_DNC_A, S_DNC_D, S_DATA_A, S_DATA_D, S_GO_A, S_GO_D, S_POLL_A, S_POLL_D
  } state_t;
  localparam int ENTRY_W = 17;
  localparam logic [1:0] REG_PUSH = 2'd0, REG_STATUS = 2'd1, REG_CTRL = 2'd2;
  localparam logic [31:0] OFS_DNC = 32'h0, OFS_READY = 32'h4, OFS_DATA = 32'h8;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam int ST_EMPTY = 0, ST_FULL = 1, ST_BUSY = 2, ST_COUNT = 4, ST_OVF = 9, ST_IRQ = 10;

  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic busy, input logic [4:0] count,
                                              input logic ovf, input logic irq);
    logic [31:0] s;
    s = '0;
    s[ST_EMPTY] = empty;
    s[ST_FULL] = full;
    s[ST_BUSY] = busy;
    s[ST_COUNT+:5] = count;
    s[ST_OVF] = ovf;
    s[ST_IRQ] = irq;
    return s;
  endfunction
endpackage

// File: rtl/oled_seq_fifo.sv
// oled_seq_fifo: synchronous FIFO of {dnc,data} entries with push/pop/flush;
// push while full is accepted only when a pop frees a slot in the same cycle.
module oled_seq_fifo
  import oled_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [ENTRY_W-1:0] i_wdata,
  output logic [ENTRY_W-1:0] o_rdata,
  output logic               o_full,
  output logic               o_empty,
  output logic [CW-1:0]      o_count
);
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic w_wr, w_rd;

  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & ~i_flush & (~o_full | w_rd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/oled_cmd_sequencer.sv
// oled_cmd_sequencer: AHB-Lite slave FIFO that replays OLED dnc/data words to
// oled_manager over a private master link. Optional IRQ via OLED_SEQ_IRQ_EN.
module oled_cmd_sequencer
  import oled_seq_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] OLED_BASE = 32'hC000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic        M_HWRITE,
  output logic [2:0]  M_HSIZE,
  output logic [31:0] M_HWDATA,
  input  logic [31:0] M_HRDATA,
  input  logic        M_HREADY
`ifdef OLED_SEQ_IRQ_EN
  ,
  output logic        IRQ
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t r_state;
  logic r_wr, r_rd, r_enable, r_ovf;
  logic [1:0] r_addr;
  logic [ENTRY_W-1:0] r_hold, w_rdata;
  logic [CW-1:0] w_count;
  logic [31:0] w_status;
  logic w_push, w_ctrl, w_flush, w_pop, w_ovf, w_done, w_full, w_empty, w_irq, w_unused;

  assign HREADYOUT = 1'b1;
  assign M_HSIZE   = HSIZE_WORD;
  assign w_push    = r_wr & (r_addr == REG_PUSH);
  assign w_ctrl    = r_wr & (r_addr == REG_CTRL);
  assign w_flush   = w_ctrl & HWDATA[1];
  assign w_pop     = (r_state == S_IDLE) & r_enable & ~w_empty & M_HREADY;
  assign w_ovf     = w_push & w_full & ~w_pop & ~w_flush;
  assign w_done    = (r_state == S_POLL_D) & M_HREADY & M_HRDATA[0];
  assign w_status  = pack_status(w_empty, w_full, r_state != S_IDLE, 5'(w_count), r_ovf, w_irq);
  assign HRDATA    = !r_rd ? '0 : r_addr == REG_STATUS ? w_status :
                     r_addr == REG_CTRL ? {31'b0, r_enable} : '0;
  assign w_unused  = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:17], M_HRDATA[31:1], w_done};

  oled_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (HWDATA[ENTRY_W-1:0]),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Address phase is registered; write data is consumed in the following data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_addr <= '0;
    end else begin
      r_wr <= HREADY & HSEL & HTRANS[1] & HWRITE;
      r_rd <= HREADY & HSEL & HTRANS[1] & ~HWRITE;
      if (HREADY) r_addr <= HADDR[3:2];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_enable <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      if (w_ctrl) r_enable <= HWDATA[0];
      if (w_ctrl & HWDATA[2]) r_ovf <= 1'b0;
      else if (w_ovf) r_ovf <= 1'b1;
    end
  end

`ifdef OLED_SEQ_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) IRQ <= 1'b0;
    else if (w_ctrl & HWDATA[3]) IRQ <= 1'b0;
    else if (w_done & w_empty) IRQ <= 1'b1;
  end
  assign w_irq = IRQ;
`else
  assign w_irq = 1'b0;
`endif

  // Bus outputs are loaded on entry to each state so they hold through stalls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_hold   <= '0;
      M_HTRANS <= HTRANS_IDLE;
      M_HADDR  <= OLED_BASE;
      M_HWRITE <= 1'b0;
      M_HWDATA <= '0;
    end else if (M_HREADY) begin
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_hold   <= w_rdata;
          r_state  <= S_DNC_A;
          M_HTRANS <= HTRANS_NONSEQ;
          M_HADDR  <= OLED_BASE + OFS_DNC;
          M_HWRITE <= 1'b1;
        end
        S_DNC_A: begin
          r_state  <= S_DNC_D;
          M_HTRANS <= HTRANS_IDLE;
          M_HWDATA <= {31'b0, r_hold[16]};
        end
        S_DNC_D: begin
          r_state  <= S_DATA_A;
          M_HTRANS <= HTRANS_NONSEQ;
          M_HADDR  <= OLED_BASE + OFS_DATA;
        end
        S_DATA_A: begin
          r_state  <= S_DATA_D;
          M_HTRANS <= HTRANS_IDLE;
          M_HWDATA <= {16'b0, r_hold[15:0]};
        end
        S_DATA_D: begin
          r_state  <= S_GO_A;
          M_HTRANS <= HTRANS_NONSEQ;
          M_HADDR  <= OLED_BASE + OFS_READY;
        end
        S_GO_A: begin
          r_state  <= S_GO_D;
          M_HTRANS <= HTRANS_IDLE;
          M_HWDATA <= '0;
        end
        S_GO_D: begin
          r_state  <= S_POLL_A;
          M_HTRANS <= HTRANS_NONSEQ;
          M_HWRITE <= 1'b0;
        end
        S_POLL_A: begin
          r_state  <= S_POLL_D;
          M_HTRANS <= HTRANS_IDLE;
        end
        S_POLL_D: if (M_HRDATA[0]) begin
          r_state <= S_IDLE;
          M_HADDR <= OLED_BASE;
        end else begin
          r_state  <= S_POLL_A;
          M_HTRANS <= HTRANS_NONSEQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// tb_oled_cmd_sequencer: directed stimulus with a scoreboard of expected master
// transfers checked by a bus monitor against a small oled_manager model.
module tb_oled_cmd_sequencer;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam logic [31:0] S_PUSH = 32'h4000_0000, S_STAT = 32'h4000_0004, S_CTRL = 32'h4000_0008;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
  } xfer_t;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic HSEL = 0, HWRITE = 0, mhready = 1;
  logic [31:0] HADDR = 0, HWDATA = 0;
  logic [1:0] HTRANS = 0;
  logic [2:0] HSIZE = 3'b010;
  logic [31:0] HRDATA, M_HADDR, M_HWDATA, M_HRDATA;
  logic HREADYOUT, M_HWRITE;
  logic [1:0] M_HTRANS;
  logic [2:0] M_HSIZE;
`ifdef OLED_SEQ_IRQ_EN
  logic irq;
  logic irq_prev = 0;
  int irq_rises = 0;
`endif

  int n_chk = 0, n_fail = 0;
  xfer_t sb[$];
  xfer_t mon_e;
  int poll_cfg = 3, poll_left = 0, go_cnt = 0;
  bit pend_go = 0, pend_dec = 0, in_data = 0;
  logic [31:0] cur_a;
  logic cur_w;

  assign M_HRDATA = {31'b0, (poll_left == 0)};

  oled_cmd_sequencer #(.DEPTH(DEPTH), .OLED_BASE(BASE)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(HSEL), .HREADY(1'b1), .HWRITE(HWRITE),
    .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA), .M_HREADY(mhready)
`ifdef OLED_SEQ_IRQ_EN
    , .IRQ(irq)
`endif
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_entry(input logic dnc, input logic [15:0] data);
    sb.push_back('{BASE, 1'b1, {31'b0, dnc}});
    sb.push_back('{BASE + 32'h8, 1'b1, {16'b0, data}});
    sb.push_back('{BASE + 32'h4, 1'b1, 32'h0});
    for (int i = 0; i <= poll_cfg; i++) sb.push_back('{BASE + 32'h4, 1'b0, 32'h0});
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
    @(negedge clk);
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
    @(negedge clk);
    HSEL = 0; HTRANS = 2'b00;
    #1 d = HRDATA;
  endtask

  task automatic push(input logic dnc, input logic [15:0] data, input bit expect_out);
    if (expect_out) exp_entry(dnc, data);
    ahb_write(S_PUSH, {15'b0, dnc, data});
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] s;
    ahb_read(S_STAT, s);
    check(name, s, exp);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ahb_read(S_STAT, s);
      ok = !s[2] && s[0] && sb.size() == 0;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: drain timeout, status 0x%0h, pending %0d", name, s, sb.size());
    end
  endtask

  // Monitor: capture address phase, compare on data-phase completion.
  always begin
    @(negedge clk);
    #1;
`ifdef OLED_SEQ_IRQ_EN
    if (irq && !irq_prev) irq_rises++;
    irq_prev = irq;
`endif
    if (!rst_n) in_data = 0;
    else if (in_data) begin
      if (mhready) begin
        in_data = 0;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL xfer: unexpected transfer addr 0x%0h write %0d", cur_a, cur_w);
        end else begin
          mon_e = sb.pop_front();
          check("xfer", {cur_a, 31'b0, cur_w, cur_w ? M_HWDATA : 32'h0},
                {mon_e.a, 31'b0, mon_e.w, mon_e.d});
        end
        if (cur_w && cur_a == BASE + 32'h4) begin
          go_cnt++;
          pend_go = 1;
        end
        if (!cur_w) pend_dec = 1;
      end
    end else if (M_HTRANS == 2'b10 && mhready) begin
      cur_a = M_HADDR;
      cur_w = M_HWRITE;
      in_data = 1;
    end
  end

  // oled_manager model: ready reads 0 for poll_cfg polls after each start.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) poll_left = 0;
    else if (pend_go) poll_left = poll_cfg;
    else if (pend_dec && poll_left > 0) poll_left--;
    pend_go = 0;
    pend_dec = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int g;
    bit hit;
    repeat (3) @(negedge clk);
    #1;
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hreadyout", HREADYOUT, 1'b1);
    check("rst_master", {M_HTRANS, M_HADDR, M_HWRITE, M_HWDATA, M_HSIZE},
          {2'b00, BASE, 1'b0, 32'h0, 3'b010});
`ifdef OLED_SEQ_IRQ_EN
    check("rst_irq", irq, 1'b0);
`endif
    @(negedge clk) rst_n = 1;
    check_status("rst_status", 32'h001);
    ahb_read(S_CTRL, r);
    check("rst_ctrl", r, 32'h1);

    poll_cfg = 3;
    push(1'b0, 16'h00AF, 1);
    wait_idle("cmd_drain");
    check_status("cmd_status", 32'h001);

    poll_cfg = 1;
    ahb_write(S_CTRL, 32'h0);
    for (int i = 0; i <= DEPTH; i++) push(i[0], 16'h0100 + 16'(i), i < DEPTH);
    check_status("full_status", 32'h282);
    check("held_while_disabled", sb.size(), DEPTH * (4 + poll_cfg));
    ahb_write(S_CTRL, 32'h1);
    wait_idle("full_drain");
    check_status("drained_ovf", 32'h201);
    ahb_write(S_CTRL, 32'h5);
    check_status("ovf_cleared", 32'h001);

    poll_cfg = 6;
    g = go_cnt;
    push(1'b1, 16'h00A1, 1);
    push(1'b1, 16'h00A2, 1);
    push(1'b1, 16'h00A3, 0);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = go_cnt >= g + 2;
    end
    check("second_entry_started", hit, 1'b1);
    ahb_write(S_CTRL, 32'h3);
    wait_idle("flush_drain");
    check_status("flush_status", 32'h001);
    check("flush_sb_empty", sb.size(), 0);

    poll_cfg = 0;
    push(1'b1, 16'h1234, 1);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = M_HTRANS == 2'b00 && M_HADDR == BASE + 32'h8;
    end
    check("reach_data_d", hit, 1'b1);
    mhready = 0;
    repeat (4) begin
      @(negedge clk);
      #1 check("stall_hold", {M_HADDR, M_HWDATA, M_HTRANS}, {BASE + 32'h8, 32'h1234, 2'b00});
    end
    @(negedge clk) mhready = 1;
    wait_idle("stall_drain");
    check_status("stall_status", 32'h001);

    poll_cfg = 3;
    push(1'b0, 16'h0055, 1);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = M_HTRANS == 2'b00 && M_HADDR == BASE + 32'h4 && M_HWRITE;
    end
    check("reach_go_d", hit, 1'b1);
    #2 rst_n = 0;
    #1;
    check("async_rst_master", {M_HTRANS, M_HADDR, M_HWRITE, M_HWDATA}, {2'b00, BASE, 1'b0, 32'h0});
    check("async_rst_hrdata", HRDATA, 32'h0);
    sb.delete();
    @(negedge clk);
    @(negedge clk) rst_n = 1;
    check_status("post_rst_status", 32'h001);

`ifdef OLED_SEQ_IRQ_EN
    poll_cfg = 1;
    ahb_write(S_CTRL, 32'h0);
    irq_rises = 0;
    push(1'b0, 16'h0011, 1);
    push(1'b1, 16'h0022, 1);
    check("irq_idle_low", irq, 1'b0);
    ahb_write(S_CTRL, 32'h1);
    wait_idle("irq_drain");
    check("irq_set", irq, 1'b1);
    check("irq_rises_once", irq_rises, 1);
    check_status("irq_status", 32'h401);
    ahb_write(S_CTRL, 32'h9);
    check_status("irq_clr_status", 32'h001);
    check("irq_cleared", irq, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
